t09_apple_spawn_ctrl: RTL and testbench
=======================================

# t09_apple_spawn_ctrl

Sequential apple-placement controller for the team_09 snake game. On reset, soft reset or an eat event, it draws random coordinates from the LFSR, scans the snake body one segment per cycle through a read port into the body store, and commits the first collision-free coordinate as the new apple position. It sits between the random source, the body register file and the pixel/collision logic. It replaces a 50-way combinational compare with a bounded, retrying scan.

## Interface
Parameters:
- MAX_LENGTH, 50, body segment capacity; seg_idx width is clog2(MAX_LENGTH).
- MAX_RETRY, 16, draws per attempt before place_fail pulses.
- RESET_CORD, 8'hC5, apple position after reset or soft reset, as {x,y}.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- s_reset  in  1  soft (game) reset, synchronous, active-high.
- eat  in  1  single-cycle pulse: the head collided with the apple.
- rand_x, rand_y  in  4 each  free-running random coordinates.
- length  in  clog2(MAX_LENGTH)+1  number of valid body segments, 0..MAX_LENGTH.
- seg_idx  out  clog2(MAX_LENGTH)  body read address.
- seg_cord  in  8  {x,y} of segment seg_idx; combinational, same cycle.
- x, y  in  4 each  pixel/cell currently being drawn.
- apple_cord  out  8  committed apple position {x,y}.
- apple_valid  out  1  apple_cord is placed and displayable.
- apple  out  1  apple_valid && apple_cord=={x,y}; combinational.
- busy  out  1  high in every state except IDLE.
- place_fail  out  1  one-cycle pulse when MAX_RETRY consecutive draws all collide.

## Operation
- FSM states: IDLE, SAMPLE, SCAN, COMMIT.
- IDLE: when eat=1, clear apple_valid and go to SAMPLE. Otherwise hold.
- SAMPLE:
  - Latch cand={rand_x,rand_y} and set seg_idx=0.
  - If length==0, go to COMMIT; otherwise go to SCAN.
- SCAN: each cycle compare seg_cord with cand.
  - Match: increment retry and go to SAMPLE.
  - No match and seg_idx==length-1: go to COMMIT.
  - No match otherwise: seg_idx++.
- Retry limit: when retry reaches MAX_RETRY on a match, pulse place_fail for that cycle, clear retry, and continue to SAMPLE. Searching never gives up.
- COMMIT: apple_cord<=cand, apple_valid<=1, retry<=0, go to IDLE.
- eat while busy is ignored; the relocation in progress already serves it.
- Reset and s_reset act identically:
  - state=IDLE, apple_cord=RESET_CORD, apple_valid=1, retry=0, seg_idx=0, place_fail=0.
  - s_reset mid-scan aborts the scan; the candidate is discarded.
- If length changes during SCAN, the new value is used from the next compare onward; no restart.
- Widths: retry counter is clog2(MAX_RETRY+1) bits. Comparisons are 8-bit equality. The terminal check uses length-1 only when length>0.

## Timing
- Reset values: apple_cord=8'hC5, apple_valid=1, apple=(x,y)==(C,5), busy=0, place_fail=0, seg_idx=0.
- eat sampled at edge n (IDLE→SAMPLE): apple_valid=0 and busy=1 from n.
- Body length L≥1, no collision:
  - SAMPLE occupies n..n+1.
  - SCAN occupies L cycles.
  - COMMIT edge at n+L+2.
  - apple_valid=1 with the new apple_cord visible after edge n+L+2 (L+2 cycles after eat).
- L=0: valid after edge n+2.
- Each collision costs (matching index+1) scan cycles plus one SAMPLE cycle.
- place_fail is registered and is high for exactly one cycle, following the edge of the MAX_RETRY-th match.

## Structure
- The shared t09 package holds:
  - cord_t (8-bit {x,y}) and the state enum (IDLE/SAMPLE/SCAN/COMMIT).
  - RESET_CORD.
  - MAX_LENGTH default, shared with the body store.
- No sub-module. The body store is external; seg_idx/seg_cord form its async read port.

## Test plan
- Reset: reset=1 for 2 cycles → apple_cord=8'hC5, apple_valid=1, busy=0. Then x=C, y=5 → apple=1.
- Clean placement: length=3, body {0x11,0x12,0x13}, rand=(7,7), eat pulse → busy for 5 cycles, then apple_cord=8'h77, apple_valid=1.
- Collision retry: length=3, rand=(1,2) on the first SAMPLE and (9,4) afterwards → one retry; final apple_cord=8'h94. Cycle count matches (2+1 scan cycles)+1+3+… per the formula.
- Retry exhaustion: with MAX_RETRY=4, rand stuck at 0x11 (body[0]) → place_fail pulses every 4 draws, busy stays 1. Releasing rand to 0x55 → commit of 8'h55.
- Soft reset mid-scan: length=40, s_reset asserted on the 10th SCAN cycle → next cycle IDLE, apple_cord=8'hC5, apple_valid=1.
- Ignored eat: eat pulsed again while busy → exactly one commit results. eat with length=0 → valid after 2 cycles.

Source files
------------

// File: rtl/t09_apple_spawn_ctrl_pkg.sv
// Shared t09 types and defaults: cell coordinates, placement FSM states,
// the apple's home position and the body store capacity.
package t09_apple_spawn_ctrl_pkg;

  localparam int MAX_LENGTH_DEF = 50;

  typedef logic [7:0] cord_t;

  localparam cord_t RESET_CORD_DEF = 8'hC5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    SCAN   = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/t09_apple_spawn_ctrl.sv
// Apple placement: draw a random cell, scan the body one segment per cycle,
// commit the first draw that hits no segment. Retries indefinitely.
module t09_apple_spawn_ctrl
  import t09_apple_spawn_ctrl_pkg::*;
#(
  parameter int    MAX_LENGTH = MAX_LENGTH_DEF,
  parameter int    MAX_RETRY  = 16,
  parameter cord_t RESET_CORD = RESET_CORD_DEF,
  localparam int   IW         = $clog2(MAX_LENGTH),
  localparam int   LW         = IW + 1,
  localparam int   RW         = $clog2(MAX_RETRY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_reset,
  input  logic          eat,
  input  logic [3:0]    rand_x,
  input  logic [3:0]    rand_y,
  input  logic [LW-1:0] length,
  output logic [IW-1:0] seg_idx,
  input  cord_t         seg_cord,
  input  logic [3:0]    x,
  input  logic [3:0]    y,
  output cord_t         apple_cord,
  output logic          apple_valid,
  output logic          apple,
  output logic          busy,
  output logic          place_fail,
  output state_t        fsm_state
);

  // Handshake: eat is a one-cycle request accepted only in IDLE; busy stays
  // high until the commit (or a reset) returns the FSM to IDLE, and
  // apple_valid rising with busy falling marks a new apple_cord.

  state_t        state_q, state_d;
  cord_t         cand;
  logic [RW-1:0] retry;
  logic          match;
  logic          last;

  assign match = (seg_cord == cand);
  // Also terminates if length shrinks to or below the current index mid-scan.
  assign last  = (({1'b0, seg_idx} + LW'(1)) >= length);

  assign busy      = (state_q != IDLE);
  assign apple     = apple_valid && (apple_cord == {x, y});
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (eat) state_d = SAMPLE;
      SAMPLE:  state_d = (length == '0) ? COMMIT : SCAN;
      SCAN: begin
        if (match)     state_d = SAMPLE;
        else if (last) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || s_reset) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || s_reset) begin
      apple_cord  <= RESET_CORD;
      apple_valid <= 1'b1;
      retry       <= '0;
      seg_idx     <= '0;
      place_fail  <= 1'b0;
      cand        <= '0;
    end else begin
      place_fail <= 1'b0;
      case (state_q)
        IDLE: begin
          if (eat) apple_valid <= 1'b0;
        end
        SAMPLE: begin
          cand    <= {rand_x, rand_y};
          seg_idx <= '0;
        end
        SCAN: begin
          if (match) begin
            // The failure pulse is informational; the search keeps drawing.
            if (retry == RW'(MAX_RETRY - 1)) begin
              place_fail <= 1'b1;
              retry      <= '0;
            end else begin
              retry <= retry + RW'(1);
            end
          end else if (!last) begin
            seg_idx <= seg_idx + IW'(1);
          end
        end
        COMMIT: begin
          apple_cord  <= cand;
          apple_valid <= 1'b1;
          retry       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t09_apple_spawn_ctrl.sv
// Directed bench for the apple placement controller: commits are checked by a
// monitor against an expected-coordinate queue; timing checked by the driver.
module tb_t09_apple_spawn_ctrl;
  import t09_apple_spawn_ctrl_pkg::*;

  localparam int IW = 6;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          reset, s_reset, eat;
  logic [3:0]    rand_x, rand_y, x, y;
  logic [LW-1:0] length;
  logic [IW-1:0] seg_idx;
  cord_t         seg_cord, apple_cord;
  logic          apple_valid, apple, busy, place_fail;
  state_t        fsm_state;

  logic [7:0] body [0:63];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int pf_cnt = 0;
  logic prev_busy = 1'b0;

  assign seg_cord = body[seg_idx];

  t09_apple_spawn_ctrl #(.MAX_LENGTH(50), .MAX_RETRY(4), .RESET_CORD(8'hC5)) dut (
    .clk(clk), .reset(reset), .s_reset(s_reset), .eat(eat),
    .rand_x(rand_x), .rand_y(rand_y), .length(length),
    .seg_idx(seg_idx), .seg_cord(seg_cord), .x(x), .y(y),
    .apple_cord(apple_cord), .apple_valid(apple_valid), .apple(apple),
    .busy(busy), .place_fail(place_fail), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // monitor: a falling busy with apple_valid high presents a new apple_cord
  always @(negedge clk) begin
    if (place_fail === 1'b1) pf_cnt++;
    if (prev_busy && busy === 1'b0 && apple_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_commit", {24'd0, apple_cord}, 32'hFFFF);
      else chk("commit_cord", {24'd0, apple_cord}, {24'd0, exp_q.pop_front()});
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic set_body3();
    body[0] = 8'h11; body[1] = 8'h12; body[2] = 8'h13;
    length = 7'd3;
  endtask

  // Pulse eat, then count busy cycles; optionally swap rand or re-pulse eat
  // at a given busy cycle.
  task automatic run_eat(input string name, input int exp_cyc, input logic [7:0] cord,
                         input int sw_at, input logic [7:0] r2, input int eat2_at);
    int cnt;
    exp_q.push_back(cord);
    @(negedge clk); eat = 1'b1;
    @(negedge clk); eat = 1'b0;
    chk({name, "_valid_low"}, {31'd0, apple_valid}, 32'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 500) begin
      cnt++;
      if (cnt == sw_at) {rand_x, rand_y} = r2;
      if (cnt == eat2_at) eat = 1'b1;
      if (cnt == eat2_at + 1) eat = 1'b0;
      @(negedge clk);
    end
    eat = 1'b0;
    if (cnt >= 500) chk({name, "_timeout"}, 32'd1, 32'd0);
    if (exp_cyc >= 0) chk({name, "_cycles"}, cnt, exp_cyc);
    chk({name, "_valid"}, {31'd0, apple_valid}, 32'd1);
    chk({name, "_cord"}, {24'd0, apple_cord}, {24'd0, cord});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) body[i] = 8'hF0;
    reset = 1'b1; s_reset = 1'b0; eat = 1'b0;
    rand_x = 4'h0; rand_y = 4'h0; x = 4'hC; y = 4'h5; length = '0;

    // reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cord", {24'd0, apple_cord}, 32'hC5);
    chk("rst_valid", {31'd0, apple_valid}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pf", {31'd0, place_fail}, 32'd0);
    chk("rst_idx", {26'd0, seg_idx}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
    chk("rst_apple_hit", {31'd0, apple}, 32'd1);
    y = 4'h4; #1;
    chk("rst_apple_miss", {31'd0, apple}, 32'd0);

    // clean placement, L=3
    set_body3();
    rand_x = 4'h7; rand_y = 4'h7;
    run_eat("clean", 5, 8'h77, 0, 8'h00, 0);
    x = 4'h7; y = 4'h7; #1;
    chk("clean_apple_hit", {31'd0, apple}, 32'd1);

    // one collision at index 1: 5 + (1+1) + 1 = 8 busy cycles
    rand_x = 4'h1; rand_y = 4'h2;
    run_eat("retry", 8, 8'h94, 2, 8'h94, 0);

    // retry exhaustion with MAX_RETRY=4: one pulse per 4 draws of 2 cycles
    rand_x = 4'h1; rand_y = 4'h1;
    pf_cnt = 0;
    exp_q.push_back(8'h55);
    @(negedge clk); eat = 1'b1;
    @(negedge clk); eat = 1'b0;
    repeat (19) @(negedge clk);
    #1;
    chk("exhaust_pf_cycles", pf_cnt, 32'd2);
    chk("exhaust_busy", {31'd0, busy}, 32'd1);
    chk("exhaust_valid_low", {31'd0, apple_valid}, 32'd0);
    rand_x = 4'h5; rand_y = 4'h5;
    for (int i = 0; i < 50 && busy === 1'b1; i++) @(negedge clk);
    chk("exhaust_done", {31'd0, busy}, 32'd0);
    chk("exhaust_cord", {24'd0, apple_cord}, 32'h55);

    // soft reset on the 10th scan cycle of a 40-segment body
    for (int i = 0; i < 40; i++) body[i] = 8'hA0 + 8'(i);
    length = 7'd40;
    rand_x = 4'h3; rand_y = 4'h3;
    exp_q.push_back(8'hC5);
    @(negedge clk); eat = 1'b1;
    @(negedge clk); eat = 1'b0;
    repeat (10) @(negedge clk);
    chk("sreset_scan_idx", {26'd0, seg_idx}, 32'd9);
    chk("sreset_in_scan", {30'd0, fsm_state}, {30'd0, SCAN});
    s_reset = 1'b1;
    @(negedge clk);
    s_reset = 1'b0;
    chk("sreset_state", {30'd0, fsm_state}, {30'd0, IDLE});
    chk("sreset_cord", {24'd0, apple_cord}, 32'hC5);
    chk("sreset_valid", {31'd0, apple_valid}, 32'd1);
    chk("sreset_idx", {26'd0, seg_idx}, 32'd0);

    // eat while busy is ignored: single commit, normal latency
    set_body3();
    rand_x = 4'h6; rand_y = 4'h6;
    run_eat("ign_eat", 5, 8'h66, 0, 8'h00, 2);
    repeat (8) @(negedge clk);
    chk("ign_eat_idle", {31'd0, busy}, 32'd0);

    // empty body commits straight from SAMPLE
    length = '0;
    rand_x = 4'h2; rand_y = 4'h3;
    run_eat("len0", 2, 8'h23, 0, 8'h00, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
